// File: rtl/cw305_pulpino_mailbox.sv
// Host <-> PULPino mailbox for the CW305 target.
//
// Host-to-core: each rising edge of the send strobe pushes I_ext_data into a small
// first-word-fall-through FIFO that the core drains through a valid/ready port.
// Core-to-host: a one-byte holding register. The core hands over a byte when the
// register is empty, and the host releases it with a rising edge of the receive ack.
//
// Ports
//   crypto_clk       clock; all state changes on its rising edge
//   reset_n_i        synchronous active-low reset
//   I_ext_data       host byte to send (already in the crypto_clk domain)
//   I_ext_flags      [0] send strobe, [1] receive ack, [2] overflow clear
//   O_pulpino_data   last byte received from the core
//   O_pulpino_flags  [0] out_valid, [1] full, [2] overflow, [3] empty, [6:4] count
//   core_rx_*        FIFO output to the core (valid/ready)
//   core_tx_*        byte input from the core (valid/ready)
module cw305_pulpino_mailbox #(
  parameter int unsigned pDEPTH     = 4,
  parameter int unsigned pCNT_WIDTH = 3
) (
  input  logic       crypto_clk,
  input  logic       reset_n_i,
  input  logic [7:0] I_ext_data,
  input  logic [7:0] I_ext_flags,
  output logic [7:0] O_pulpino_data,
  output logic [7:0] O_pulpino_flags,
  output logic [7:0] core_rx_data,
  output logic       core_rx_valid,
  input  logic       core_rx_ready,
  input  logic [7:0] core_tx_data,
  input  logic       core_tx_valid,
  output logic       core_tx_ready
);

  localparam int unsigned PtrW = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
  localparam logic [pCNT_WIDTH-1:0] CntFull = pCNT_WIDTH'(pDEPTH);

  typedef enum logic [0:0] {StIdle, StHold} tx_state_e;

  // Host flag edge detection
  logic [2:0] prev_flags_q;
  logic       send_ev, ack_ev, clr_ev;
  logic       unused_flags;

  assign unused_flags = ^I_ext_flags[7:3];
  assign send_ev      = I_ext_flags[0] & ~prev_flags_q[0];
  assign ack_ev       = I_ext_flags[1] & ~prev_flags_q[1];
  assign clr_ev       = I_ext_flags[2] & ~prev_flags_q[2];

  // Loaded during reset too, so a flag held high across reset release is not an edge.
  always_ff @(posedge crypto_clk) begin
    prev_flags_q <= I_ext_flags[2:0];
  end

  // Host-to-core FIFO
  logic [7:0]            mem_q [pDEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [pCNT_WIDTH-1:0] count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  full, empty, push, pop, drop;

  assign full  = (count_q == CntFull);
  assign empty = (count_q == '0);
  assign pop   = core_rx_valid & core_rx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push  = send_ev & (~full | pop);
  assign drop  = send_ev & full & ~pop;

  assign core_rx_valid = ~empty;
  assign core_rx_data  = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new overflow wins over a simultaneous clear.
    if (drop)        ovf_d = 1'b1;
    else if (clr_ev) ovf_d = 1'b0;
  end

  always_ff @(posedge crypto_clk) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge crypto_clk) begin
    if (reset_n_i && push) mem_q[wptr_q] <= I_ext_data;
  end

  // Core-to-host holding register
  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] out_data_q, out_data_d;

  always_comb begin
    tx_state_d    = tx_state_q;
    out_data_d    = out_data_q;
    core_tx_ready = 1'b0;
    unique case (tx_state_q)
      StIdle: begin
        core_tx_ready = 1'b1;
        if (core_tx_valid) begin
          tx_state_d = StHold;
          out_data_d = core_tx_data;
        end
      end
      StHold: begin
        if (ack_ev) tx_state_d = StIdle;
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_ff @(posedge crypto_clk) begin
    if (!reset_n_i) begin
      tx_state_q <= StIdle;
      out_data_q <= 8'h00;
    end else begin
      tx_state_q <= tx_state_d;
      out_data_q <= out_data_d;
    end
  end

  // Status decoded from registered state only.
  logic [2:0] count3;
  assign count3 = 3'(count_q);

  assign O_pulpino_data  = out_data_q;
  assign O_pulpino_flags = {1'b0, count3, empty, ovf_q, full, tx_state_q == StHold};

endmodule
